// File: rtl/pc_sequencer_if.sv
// Redirect/fetch bundle between the next-PC sequencer and the PC register, hazard unit and imem.
// Pure wiring, no latency; no flow control beyond the imem request/acknowledge pair.
// master = the sequencer side, slave = the pipeline/memory side.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc_i;
    logic              stall_i;
    logic              branch_taken_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic              jump_i;
    logic [ADDR_W-1:0] jump_target_i;
    logic              imem_ack_i;
    logic [ADDR_W-1:0] next_pc_o;
    logic              imem_req_o;
    logic              if_valid_o;
    logic              flush_ifid_o;
    logic              flush_idex_o;

    modport master (
        input  pc_i, stall_i, branch_taken_i, branch_target_i,
               jump_i, jump_target_i, imem_ack_i,
        output next_pc_o, imem_req_o, if_valid_o, flush_ifid_o, flush_idex_o
    );

    modport slave (
        output pc_i, stall_i, branch_taken_i, branch_target_i,
               jump_i, jump_target_i, imem_ack_i,
        input  next_pc_o, imem_req_o, if_valid_o, flush_ifid_o, flush_idex_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequential fetch, branch/jump redirect with flushes, stall hold.
// Zero-cycle decision (outputs combinational); the PC register loads next_pc_o on the next edge.
// Backpressure: a missing imem ack holds the PC; a redirect during an open fetch is parked in DRAIN.
module pc_sequencer #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    pc_sequencer_if.master        bus
);

    typedef enum logic [1:0] {
        RST_S = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;

    logic [ADDR_W-1:0] br_tgt, redir_tgt, pc_inc;
    logic              redirect;

    logic [ADDR_W-1:0] next_pc;
    logic              imem_req, if_valid, flush_ifid, flush_idex;

    assign br_tgt    = bus.branch_target_i & ALIGN_MASK;
    assign redir_tgt = bus.branch_taken_i ? br_tgt : (bus.jump_target_i & ALIGN_MASK);
    assign redirect  = bus.branch_taken_i | bus.jump_i;
    assign pc_inc    = bus.pc_i + ADDR_W'(4);

    always_comb begin
        next_pc       = bus.pc_i;
        imem_req      = 1'b1;
        if_valid      = 1'b0;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        state_d       = state_q;
        pend_target_d = pend_target_q;
        case (state_q)
            RST_S: begin
                next_pc  = RESET_PC;
                imem_req = 1'b0;
                state_d  = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    // Jump only squashes IF/ID; the EX branch also kills the ID/EX slot.
                    flush_ifid = 1'b1;
                    flush_idex = bus.branch_taken_i;
                    if (bus.imem_ack_i) begin
                        next_pc = redir_tgt;
                    end else begin
                        pend_target_d = redir_tgt;
                        state_d       = DRAIN;
                    end
                end else if (!bus.stall_i && bus.imem_ack_i) begin
                    next_pc  = pc_inc;
                    if_valid = 1'b1;
                end
            end
            DRAIN: begin
                // The outstanding fetch is on the wrong path: hold PC until it returns, then drop it.
                if (bus.branch_taken_i) begin
                    flush_ifid    = 1'b1;
                    flush_idex    = 1'b1;
                    pend_target_d = br_tgt;
                end
                if (bus.imem_ack_i) begin
                    next_pc = bus.branch_taken_i ? br_tgt : pend_target_q;
                    state_d = FETCH;
                end
            end
            default: begin
                next_pc  = RESET_PC;
                imem_req = 1'b0;
                state_d  = RST_S;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RST_S;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign bus.next_pc_o    = next_pc;
    assign bus.imem_req_o   = imem_req;
    assign bus.if_valid_o   = if_valid;
    assign bus.flush_ifid_o = flush_ifid;
    assign bus.flush_idex_o = flush_idex;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: each cycle's expected outputs are queued when inputs are driven.
module tb_pc_sequencer;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic        ack;
    } stim_t;

    typedef struct packed {
        logic [31:0] npc;
        logic        req;
        logic        vld;
        logic        fi;
        logic        fx;
    } obs_t;

    obs_t sb[$];

    function automatic stim_t S(input logic [31:0] pc, input logic stall, input logic br,
                                input logic [31:0] bt, input logic j, input logic [31:0] jt,
                                input logic ack);
        S = '{pc: pc, stall: stall, br: br, bt: bt, j: j, jt: jt, ack: ack};
    endfunction

    function automatic obs_t O(input logic [31:0] npc, input logic req, input logic vld,
                               input logic fi, input logic fx);
        O = '{npc: npc, req: req, vld: vld, fi: fi, fx: fx};
    endfunction

    function automatic obs_t sample();
        sample = '{npc: bus.next_pc_o, req: bus.imem_req_o, vld: bus.if_valid_o,
                   fi: bus.flush_ifid_o, fx: bus.flush_idex_o};
    endfunction

    task automatic set_inputs(input stim_t s);
        bus.pc_i            = s.pc;
        bus.stall_i         = s.stall;
        bus.branch_taken_i  = s.br;
        bus.branch_target_i = s.bt;
        bus.jump_i          = s.j;
        bus.jump_target_i   = s.jt;
        bus.imem_ack_i      = s.ack;
    endtask

    task automatic drive(input stim_t s, input obs_t e);
        @(posedge clk_i);
        #1;
        set_inputs(s);
        sb.push_back(e);
    endtask

    task automatic test_reset();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        // Inputs active during reset must be ignored.
        set_inputs(S(32'h1234, 1'b0, 1'b1, 32'h88, 1'b1, 32'h99, 1'b1));
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        sb.push_back(O(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_low: got %h/%b%b%b%b want %h/%b%b%b%b",
                     got.npc, got.req, got.vld, got.fi, got.fx, want.npc, want.req, want.vld, want.fi, want.fx);
        end
        // Release: first cycle stays in RST_S and presents RESET_PC.
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        set_inputs(S(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
        sb.push_back(O(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk_i);
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_release: got %h/%b%b%b%b want %h/%b%b%b%b",
                     got.npc, got.req, got.vld, got.fi, got.fx, want.npc, want.req, want.vld, want.fi, want.fx);
        end
        for (int k = 0; k < 3; k++) begin
            st.push_back(S(32'(4 * k), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
            ex.push_back(O(32'(4 * k + 4), 1'b1, 1'b1, 1'b0, 1'b0));
        end
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            @(negedge clk_i);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_seq[%0d]: got %h/%b%b%b%b want %h/%b%b%b%b", i,
                         got.npc, got.req, got.vld, got.fi, got.fx, want.npc, want.req, want.vld, want.fi, want.fx);
            end
        end
    endtask

    task automatic test_alternate_ack();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        logic [31:0] pc = 32'hC;
        for (int k = 0; k < 6; k++) begin
            logic ack = (k % 2) == 1;
            st.push_back(S(pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ack));
            ex.push_back(O(ack ? pc + 32'd4 : pc, 1'b1, ack, 1'b0, 1'b0));
            if (ack) pc = pc + 32'd4;
        end
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            @(negedge clk_i);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL alt_ack[%0d]: got %h/%b%b%b%b want %h/%b%b%b%b", i,
                         got.npc, got.req, got.vld, got.fi, got.fx, want.npc, want.req, want.vld, want.fi, want.fx);
            end
        end
    endtask

    task automatic test_branch_ack();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(32'h18,  1'b0, 1'b1, 32'h103, 1'b0, 32'h0,   1'b1)); ex.push_back(O(32'h100, 1'b1, 1'b0, 1'b1, 1'b1));
        st.push_back(S(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1)); ex.push_back(O(32'h104, 1'b1, 1'b1, 1'b0, 1'b0));
        // Branch and jump together: branch target and both flushes.
        st.push_back(S(32'h104, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1)); ex.push_back(O(32'h200, 1'b1, 1'b0, 1'b1, 1'b1));
        st.push_back(S(32'h200, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1)); ex.push_back(O(32'h204, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            @(negedge clk_i);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL branch_ack[%0d]: got %h/%b%b%b%b want %h/%b%b%b%b", i,
                         got.npc, got.req, got.vld, got.fi, got.fx, want.npc, want.req, want.vld, want.fi, want.fx);
            end
        end
    endtask

    task automatic test_jump_drain();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(32'h204, 1'b0, 1'b0, 32'h0, 1'b1, 32'h41, 1'b0)); ex.push_back(O(32'h204, 1'b1, 1'b0, 1'b1, 1'b0));
        st.push_back(S(32'h204, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0)); ex.push_back(O(32'h204, 1'b1, 1'b0, 1'b0, 1'b0));
        st.push_back(S(32'h204, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0)); ex.push_back(O(32'h204, 1'b1, 1'b0, 1'b0, 1'b0));
        st.push_back(S(32'h204, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1)); ex.push_back(O(32'h40,  1'b1, 1'b0, 1'b0, 1'b0));
        st.push_back(S(32'h40,  1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1)); ex.push_back(O(32'h44,  1'b1, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            @(negedge clk_i);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL jump_drain[%0d]: got %h/%b%b%b%b want %h/%b%b%b%b", i,
                         got.npc, got.req, got.vld, got.fi, got.fx, want.npc, want.req, want.vld, want.fi, want.fx);
            end
        end
    endtask

    task automatic test_drain_override();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(32'h44,  1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  1'b0)); ex.push_back(O(32'h44,  1'b1, 1'b0, 1'b1, 1'b0));
        st.push_back(S(32'h44,  1'b0, 1'b1, 32'h82,  1'b0, 32'h0,   1'b0)); ex.push_back(O(32'h44,  1'b1, 1'b0, 1'b1, 1'b1));
        st.push_back(S(32'h44,  1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0)); ex.push_back(O(32'h44,  1'b1, 1'b0, 1'b0, 1'b0));
        st.push_back(S(32'h44,  1'b1, 1'b0, 32'h0,   1'b1, 32'h300, 1'b1)); ex.push_back(O(32'h80,  1'b1, 1'b0, 1'b0, 1'b0));
        st.push_back(S(32'h80,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1)); ex.push_back(O(32'h84,  1'b1, 1'b1, 1'b0, 1'b0));
        // Branch arriving together with the draining ack goes straight to next_pc.
        st.push_back(S(32'h84,  1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0)); ex.push_back(O(32'h84,  1'b1, 1'b0, 1'b1, 1'b0));
        st.push_back(S(32'h84,  1'b0, 1'b1, 32'h501, 1'b0, 32'h0,   1'b1)); ex.push_back(O(32'h500, 1'b1, 1'b0, 1'b1, 1'b1));
        st.push_back(S(32'h500, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1)); ex.push_back(O(32'h504, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            @(negedge clk_i);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL drain_override[%0d]: got %h/%b%b%b%b want %h/%b%b%b%b", i,
                         got.npc, got.req, got.vld, got.fi, got.fx, want.npc, want.req, want.vld, want.fi, want.fx);
            end
        end
    endtask

    task automatic test_stall_wrap();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(32'h20,        1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1)); ex.push_back(O(32'h20,  1'b1, 1'b0, 1'b0, 1'b0));
        st.push_back(S(32'h20,        1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1)); ex.push_back(O(32'h24,  1'b1, 1'b1, 1'b0, 1'b0));
        st.push_back(S(32'h24,        1'b1, 1'b1, 32'h60, 1'b0, 32'h0, 1'b1)); ex.push_back(O(32'h60,  1'b1, 1'b0, 1'b1, 1'b1));
        st.push_back(S(32'h60,        1'b1, 1'b0, 32'h0,  1'b1, 32'h8, 1'b1)); ex.push_back(O(32'h8,   1'b1, 1'b0, 1'b1, 1'b0));
        st.push_back(S(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0)); ex.push_back(O(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0));
        st.push_back(S(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1)); ex.push_back(O(32'h0,   1'b1, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], ex[i]);
            @(negedge clk_i);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL stall_wrap[%0d]: got %h/%b%b%b%b want %h/%b%b%b%b", i,
                         got.npc, got.req, got.vld, got.fi, got.fx, want.npc, want.req, want.vld, want.fi, want.fx);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h700, 1'b0)); ex.push_back(O(32'h0, 1'b1, 1'b0, 1'b1, 1'b0));
        st.push_back(S(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0)); ex.push_back(O(32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        // Reset asserted here; the first released cycle is RST_S again.
        st.push_back(S(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1)); ex.push_back(O(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        st.push_back(S(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1)); ex.push_back(O(32'h4, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < st.size(); i++) begin
            if (i == 2) begin
                @(posedge clk_i);
                #1;
                rst_n = 1'b0;
                sb.push_back(O(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
                set_inputs(S(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
                @(negedge clk_i);
                got = sample(); want = sb.pop_front(); checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL mid_drain_reset: got %h/%b%b%b%b want %h/%b%b%b%b",
                             got.npc, got.req, got.vld, got.fi, got.fx, want.npc, want.req, want.vld, want.fi, want.fx);
                end
                @(posedge clk_i);
                #1;
                rst_n = 1'b1;
                set_inputs(st[i]);
                sb.push_back(ex[i]);
            end else begin
                drive(st[i], ex[i]);
            end
            @(negedge clk_i);
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid_drain[%0d]: got %h/%b%b%b%b want %h/%b%b%b%b", i,
                         got.npc, got.req, got.vld, got.fi, got.fx, want.npc, want.req, want.vld, want.fi, want.fx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alternate_ack();
        test_branch_ack();
        test_jump_drain();
        test_drain_override();
        test_stall_wrap();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the 5-stage pipeline.
- Drives the load input of the program-counter register from that register's current value.
- Sequences instruction-memory fetch requests with variable-latency acknowledge.
- Arbitrates redirect sources (EX branch, ID jump, hazard stall) and issues the matching IF/ID and ID/EX flushes.
- Holds a pending redirect when a branch or jump resolves while a fetch is still outstanding.

Parameters:
RESET_PC, 32'h0000_0000, address loaded into the PC on the first cycle after reset release
ADDR_W, 32, PC and target width

Ports:
clk_i  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
pc_i  in  ADDR_W  current PC (program-counter register output)
stall_i  in  1  load-use hazard hold from hazard unit
branch_taken_i  in  1  EX-stage branch resolved taken
branch_target_i  in  ADDR_W  EX-stage branch target
jump_i  in  1  ID-stage unconditional jump
jump_target_i  in  ADDR_W  ID-stage jump target
imem_ack_i  in  1  instruction memory has returned data for address pc_i
next_pc_o  out  ADDR_W  next PC (program-counter register load value)
imem_req_o  out  1  fetch request at address pc_i
if_valid_o  out  1  instruction returned this cycle is written into IF/ID as valid
flush_ifid_o  out  1  squash IF/ID contents
flush_idex_o  out  1  squash ID/EX contents

Behaviour:
- Registered state:
  - 2-bit FSM: RST_S, FETCH, DRAIN.
  - pend_target register, ADDR_W bits.
- Reset values (rst_n low):
  - State = RST_S; pend_target = 0.
  - next_pc_o = RESET_PC; imem_req_o = 0; if_valid_o = 0; flush_ifid_o = 0; flush_idex_o = 0.
- All outputs are combinational from the state, pend_target and the inputs. Zero-cycle decision latency; the PC updates on the next clk_i edge.
- Target alignment: every target has bits [1:0] forced to 0 before use or latching.
- Sequential increment: pc_i + 4, mod 2^ADDR_W (0xFFFF_FFFC wraps to 0).
- Redirect priority, highest first: branch_taken_i, jump_i, stall_i, sequential.
- Redirect target: branch_target_i when branch_taken_i, else jump_target_i.

RST_S:
- Outputs take their reset values; next_pc_o = RESET_PC.
- Always moves to FETCH on the next edge; ignores every input.

FETCH (imem_req_o = 1):
- branch_taken_i:
  - flush_ifid_o = 1 and flush_idex_o = 1; if_valid_o = 0.
  - With imem_ack_i: next_pc_o = target; stay in FETCH.
  - Without imem_ack_i: next_pc_o = pc_i; pend_target <= target; go to DRAIN.
- jump_i (no branch): same as branch, except flush_idex_o = 0.
- stall_i only:
  - next_pc_o = pc_i; if_valid_o = 0; no flush.
  - An acknowledged instruction is discarded and refetched.
- No event:
  - imem_ack_i: next_pc_o = pc_i + 4; if_valid_o = 1.
  - No ack: next_pc_o = pc_i; if_valid_o = 0.

DRAIN (imem_req_o = 1, if_valid_o = 0 always):
- branch_taken_i: pend_target <= new target; flush_ifid_o = 1; flush_idex_o = 1.
- If branch_taken_i coincides with imem_ack_i, the new target is used directly for next_pc_o.
- jump_i and stall_i are ignored; ID holds a bubble after the flush.
- Without imem_ack_i: next_pc_o = pc_i.
- With imem_ack_i: next_pc_o = pend_target (or the new branch target); the returned instruction is dropped; go to FETCH.

Boundary rules:
- Reset mid-DRAIN: the pending redirect is lost and the PC restarts at RESET_PC.
- imem_ack_i outside FETCH/DRAIN is ignored.
- Branch and jump in the same cycle: the branch wins and its flush covers the jump.
- Never two valid instructions for one pc_i.

Test Plan:
- Reset release, RESET_PC=0, ack every cycle -> next_pc_o=0 in cycle 0; cycles 1-3 show pc 0,4,8 with if_valid_o=1; imem_req_o=0 during reset.
- Ack every other cycle, no events -> next_pc_o holds pc_i on non-ack cycles; if_valid_o pulses only with ack; PC advances 4 per ack.
- branch_taken_i with target 0x0000_0103 and ack same cycle -> next_pc_o=0x100; flush_ifid_o=1 and flush_idex_o=1 for exactly one cycle; if_valid_o=0.
- jump_i to 0x40 with no ack for 3 cycles -> DRAIN entered; next_pc_o=pc_i until ack; on ack next_pc_o=0x40 with if_valid_o=0; flush_ifid_o only, one cycle.
- In DRAIN, pending 0x40, then branch_taken_i to 0x80 -> pend overwritten; next_pc_o=0x80 on ack; jump_i asserted in DRAIN has no effect.
- stall_i with ack at pc 0x20 -> next_pc_o=0x20, if_valid_o=0; next cycle with no stall, pc 0x20 is refetched. Also: pc_i=0xFFFF_FFFC with ack -> next_pc_o=0. Also: rst_n low mid-DRAIN -> RST_S, then PC restarts at RESET_PC.
